// File: rtl/tcell_row_search_pkg.sv
// Shared defaults and helpers for the unrank table-row search engine.
package tcell_row_search_pkg;

    localparam int DEF_NUM_WIDTH  = 10;
    localparam int DEF_CELL_WIDTH = 10;
    localparam int DEF_DEPTH      = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tcell_row_search_if.sv
// Bundle of table-write, request and result signals for tcell_row_search.
import tcell_row_search_pkg::*;

interface tcell_row_search_if #(
    parameter int NUM_WIDTH  = DEF_NUM_WIDTH,
    parameter int CELL_WIDTH = DEF_CELL_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int IDX_WIDTH  = $clog2(DEPTH + 1)
);
    logic                  wr_en;
    logic [IDX_WIDTH-1:0]  wr_addr;
    logic [CELL_WIDTH-1:0] wr_data;
    logic                  clr;
    // Both channels use valid/ready: a beat transfers on the rising edge where
    // valid && ready; the sender holds valid and payload stable until then.
    logic                  in_valid;
    logic                  in_ready;
    logic [NUM_WIDTH-1:0]  in_num;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDX_WIDTH-1:0]  out_idx;
    logic [NUM_WIDTH-1:0]  out_rem;
    logic                  out_hit;

    modport master (
        output wr_en, wr_addr, wr_data, clr, in_valid, in_num, out_ready,
        input  in_ready, out_valid, out_idx, out_rem, out_hit
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, clr, in_valid, in_num, out_ready,
        output in_ready, out_valid, out_idx, out_rem, out_hit
    );
endinterface

// File: rtl/tcell_row_search_prio_enc.sv
// Priority encoder: index of the lowest set bit of gt, or DEPTH when none is set.
import tcell_row_search_pkg::*;

module tcell_prio_enc #(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int IDX_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0]     gt,
    output logic [IDX_WIDTH-1:0] idx
);
    always_comb begin
        idx = IDX_WIDTH'(DEPTH);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (gt[i]) idx = IDX_WIDTH'(i);
        end
    end
endmodule

// File: rtl/tcell_row_search.sv
// Loadable row of DEPTH cells with a two-stage search: first cell > num and the
// remainder of num over the preceding cell.
import tcell_row_search_pkg::*;

module tcell_row_search #(
    parameter int NUM_WIDTH  = DEF_NUM_WIDTH,
    parameter int CELL_WIDTH = DEF_CELL_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input logic              clk,
    input logic              rst,
    tcell_row_search_if.slave bus
);
    localparam int IDX_WIDTH = $clog2(DEPTH + 1);
    localparam int CMP_W     = max_int(NUM_WIDTH, CELL_WIDTH);

    logic [CELL_WIDTH-1:0] cells [DEPTH];
    logic [DEPTH-1:0]      gt;
    logic [IDX_WIDTH-1:0]  enc_idx;
    logic [CMP_W-1:0]      sel_base;
    logic                  advance;
    logic                  accept;

    logic                  s1_valid;
    logic [NUM_WIDTH-1:0]  s1_num;
    logic [IDX_WIDTH-1:0]  s1_idx;
    logic [CMP_W-1:0]      s1_base;
    logic [CMP_W-1:0]      rem_full;

    logic                  s2_valid;
    logic [IDX_WIDTH-1:0]  s2_idx;
    logic [NUM_WIDTH-1:0]  s2_rem;
    logic                  s2_hit;

    assign advance      = !s2_valid || bus.out_ready;
    assign accept       = bus.in_valid && advance;
    assign bus.in_ready = advance;

    // Addresses at or beyond DEPTH match no cell, so they are silently dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) cells[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.wr_en && (bus.wr_addr == IDX_WIDTH'(i))) cells[i] <= bus.wr_data;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        assign gt[g] = CMP_W'(cells[g]) > CMP_W'(bus.in_num);
    end

    tcell_prio_enc #(
        .DEPTH     (DEPTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_enc (
        .gt  (gt),
        .idx (enc_idx)
    );

    always_comb begin
        sel_base = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            if (enc_idx == IDX_WIDTH'(i)) sel_base = CMP_W'(cells[i-1]);
        end
    end

    // The base never exceeds num, so the low NUM_WIDTH bits are the exact remainder.
    assign rem_full = CMP_W'(s1_num) - s1_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_num   <= '0;
            s1_idx   <= '0;
            s1_base  <= '0;
            s2_valid <= 1'b0;
            s2_idx   <= '0;
            s2_rem   <= '0;
            s2_hit   <= 1'b0;
        end else if (bus.clr) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_idx   <= '0;
            s2_rem   <= '0;
            s2_hit   <= 1'b0;
        end else if (advance) begin
            s1_valid <= accept;
            if (accept) begin
                s1_num  <= bus.in_num;
                s1_idx  <= enc_idx;
                s1_base <= sel_base;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_idx <= s1_idx;
                s2_rem <= rem_full[NUM_WIDTH-1:0];
                s2_hit <= (s1_idx != IDX_WIDTH'(DEPTH));
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_idx   = s2_idx;
    assign bus.out_rem   = s2_rem;
    assign bus.out_hit   = s2_hit;
endmodule

// File: tb/tb_tcell_row_search.sv
// Directed bench for tcell_row_search with DEPTH=4 and table {1,3,6,10}.
module tb_tcell_row_search;
    localparam int NW = 10;
    localparam int CW = 10;
    localparam int D  = 4;
    localparam int IW = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tcell_row_search_if #(.NUM_WIDTH(NW), .CELL_WIDTH(CW), .DEPTH(D)) bus();

    tcell_row_search #(.NUM_WIDTH(NW), .CELL_WIDTH(CW), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // result word: {valid, idx, rem, hit}
    function automatic logic [14:0] res(input logic v, input logic [IW-1:0] i,
                                        input logic [NW-1:0] r, input logic h);
        return {v, i, r, h};
    endfunction

    function automatic logic [14:0] obs();
        return {bus.out_valid, bus.out_idx, bus.out_rem, bus.out_hit};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cell(input int a, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = IW'(a);
        bus.wr_data = CW'(d);
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic load_table();
        write_cell(0, 1);
        write_cell(1, 3);
        write_cell(2, 6);
        write_cell(3, 10);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if (obs() !== res(1'b0, 3'd0, 10'd0, 1'b0)) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", obs(), res(1'b0, 3'd0, 10'd0, 1'b0));
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int nums [4] = '{0, 4, 10, 1023};
        int idxs [4] = '{0, 2, 4, 4};
        int rems [4] = '{0, 1, 0, 1013};
        int hits [4] = '{1, 1, 0, 0};
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_num   = NW'(nums[k]);
            tick();
            bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_latency num=%0d out_valid=%b exp=0", nums[k], bus.out_valid);
            end
            tick();
            checks++;
            if (obs() !== res(1'b1, IW'(idxs[k]), NW'(rems[k]), hits[k][0])) begin
                errors++;
                $display("FAIL single num=%0d got=%h exp=%h", nums[k], obs(),
                         res(1'b1, IW'(idxs[k]), NW'(rems[k]), hits[k][0]));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int nums [4] = '{2, 5, 6, 9};
        int idxs [4] = '{1, 2, 3, 3};
        int rems [4] = '{1, 2, 0, 3};
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_num   = NW'(nums[k]);
            tick();
            if (k == 0) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_latency out_valid=%b exp=0", bus.out_valid);
                end
            end else begin
                checks++;
                if (obs() !== res(1'b1, IW'(idxs[k-1]), NW'(rems[k-1]), 1'b1)) begin
                    errors++;
                    $display("FAIL b2b_%0d got=%h exp=%h", k - 1, obs(),
                             res(1'b1, IW'(idxs[k-1]), NW'(rems[k-1]), 1'b1));
                end
            end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (obs() !== res(1'b1, IW'(idxs[3]), NW'(rems[3]), 1'b1)) begin
            errors++;
            $display("FAIL b2b_3 got=%h exp=%h", obs(), res(1'b1, IW'(idxs[3]), NW'(rems[3]), 1'b1));
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain out_valid=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_num    = NW'(0);
        tick();
        bus.in_num    = NW'(4);
        tick();
        bus.in_valid  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", k, bus.in_ready);
            end
            checks++;
            if (obs() !== res(1'b1, 3'd0, 10'd0, 1'b1)) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got=%h exp=%h", k, obs(), res(1'b1, 3'd0, 10'd0, 1'b1));
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (obs() !== res(1'b1, 3'd2, 10'd1, 1'b1)) begin
            errors++;
            $display("FAIL stall_second got=%h exp=%h", obs(), res(1'b1, 3'd2, 10'd1, 1'b1));
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain out_valid=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_write_collide();
        bus.wr_en    = 1'b1;
        bus.wr_addr  = IW'(2);
        bus.wr_data  = CW'(4);
        bus.in_valid = 1'b1;
        bus.in_num   = NW'(5);
        tick();
        bus.wr_en    = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (obs() !== res(1'b1, 3'd2, 10'd2, 1'b1)) begin
            errors++;
            $display("FAIL collide_old got=%h exp=%h", obs(), res(1'b1, 3'd2, 10'd2, 1'b1));
        end
        tick();
        checks++;
        if (obs() !== res(1'b1, 3'd3, 10'd1, 1'b1)) begin
            errors++;
            $display("FAIL collide_new got=%h exp=%h", obs(), res(1'b1, 3'd3, 10'd1, 1'b1));
        end
        tick();
        write_cell(2, 6);
    endtask

    task automatic test_async_reset();
        bus.in_valid = 1'b1;
        bus.in_num   = NW'(4);
        tick();
        bus.in_num   = NW'(6);
        tick();
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs() !== res(1'b0, 3'd0, 10'd0, 1'b0)) begin
            errors++;
            $display("FAIL async_rst_outputs got=%h exp=%h", obs(), res(1'b0, 3'd0, 10'd0, 1'b0));
        end
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL async_rst_stale cyc=%0d out_valid=%b exp=0", k, bus.out_valid);
            end
        end
        // all cells now 0: nothing exceeds num=7
        bus.in_valid = 1'b1;
        bus.in_num   = NW'(7);
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (obs() !== res(1'b1, 3'd4, 10'd7, 1'b0)) begin
            errors++;
            $display("FAIL async_rst_cells got=%h exp=%h", obs(), res(1'b1, 3'd4, 10'd7, 1'b0));
        end
        tick();
        load_table();
    endtask

    task automatic test_clr();
        bus.in_valid = 1'b1;
        bus.in_num   = NW'(2);
        tick();
        bus.in_num   = NW'(5);
        tick();
        bus.in_num   = NW'(9);
        bus.clr      = 1'b1;
        tick();
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (obs() !== res(1'b0, 3'd0, 10'd0, 1'b0)) begin
            errors++;
            $display("FAIL clr_outputs got=%h exp=%h", obs(), res(1'b0, 3'd0, 10'd0, 1'b0));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL clr_emit cyc=%0d out_valid=%b exp=0", k, bus.out_valid);
            end
        end
        write_cell(4, 0);
        bus.in_valid = 1'b1;
        bus.in_num   = NW'(0);
        tick();
        bus.in_num   = NW'(9);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (obs() !== res(1'b1, 3'd0, 10'd0, 1'b1)) begin
            errors++;
            $display("FAIL clr_table0 got=%h exp=%h", obs(), res(1'b1, 3'd0, 10'd0, 1'b1));
        end
        tick();
        checks++;
        if (obs() !== res(1'b1, 3'd3, 10'd3, 1'b1)) begin
            errors++;
            $display("FAIL clr_table9 got=%h exp=%h", obs(), res(1'b1, 3'd3, 10'd3, 1'b1));
        end
        tick();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_num    = '0;
        bus.out_ready = 1'b1;
        test_reset();
        load_table();
        test_single();
        test_back_to_back();
        test_stall();
        test_write_collide();
        test_async_reset();
        test_clr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
